kbd_spi_tx: RTL and testbench

SPI-mode-0 transmitter that drives the keyboard link into the main CPLD (KBD_CS / KBD_CLK / KBD_DI) from the keyboard/PS2 controller side. It serialises a snapshot of the 40-bit ZX key matrix plus an 8-bit status byte (magic, turbo, pause etc.). Frames are sent on request or on a periodic auto-refresh timer.

---
 rtl/kbd_spi_tx.sv | 203 ++++++++++++++++++++
 tb/tb_kbd_spi_tx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_spi_tx.sv
// kbd_spi_tx: SPI mode-0 transmitter sending {status, key matrix} frames to the main CPLD.
// Frames start on request or on the auto-refresh timer; requests arriving during a frame coalesce.
module kbd_spi_tx #(
    parameter int unsigned CLK_DIV     = 7,
    parameter int unsigned FRAME_BITS  = 48,
    parameter int unsigned AUTO_PERIOD = 28000,
    parameter int unsigned GAP_CYCLES  = 14
) (
    input  logic        clk14m,
    input  logic        rst,
    input  logic [39:0] matrix,
    input  logic [7:0]  status,
    input  logic        send_req,
    output logic        kbd_cs,
    output logic        kbd_clk,
    output logic        kbd_di,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int unsigned AUTO_W  = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam bit          AUTO_EN = (AUTO_PERIOD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [FRAME_BITS-1:0]   r_shreg;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_cs;
    logic                    r_clk;
    logic                    r_di;
    logic                    r_pending;
    logic [AUTO_W-1:0]       r_auto_cnt;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [FRAME_BITS-1:0]   w_shreg_nxt;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic                    w_cs_nxt;
    logic                    w_clk_nxt;
    logic                    w_di_nxt;
    logic                    w_start;
    logic                    w_in_frame;
    logic                    w_div_end;
    logic                    w_gap_end;
    logic                    w_auto_hit;

    assign w_div_end  = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_gap_end  = (r_cnt == CNT_W'(GAP_CYCLES - 1));
    assign w_auto_hit = AUTO_EN && (r_auto_cnt == AUTO_W'(AUTO_PERIOD - 1));

    assign kbd_cs  = r_cs;
    assign kbd_clk = r_clk;
    assign kbd_di  = r_di;
    assign busy    = r_busy;
    assign done    = r_done;

    // Free-running auto-refresh counter; wraps on the request cycle.
    always_ff @(posedge clk14m or posedge rst) begin
        if (rst) begin
            r_auto_cnt <= '0;
        end else if (!AUTO_EN || w_auto_hit) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
        end
    end

    // Pending request flag; a new request beats the clear from a frame start.
    always_ff @(posedge clk14m or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= send_req | w_auto_hit | (r_pending & ~w_start);
        end
    end

    // FSM state, phase counters, shift register and registered outputs.
    always_ff @(posedge clk14m or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cs    <= 1'b1;
            r_clk   <= 1'b0;
            r_di    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shreg <= w_shreg_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cs    <= w_cs_nxt;
            r_clk   <= w_clk_nxt;
            r_di    <= w_di_nxt;
        end
    end

    // Next-state logic; the gap exit chains straight into a new frame when one is pending.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_start     = 1'b0;
        w_in_frame  = 1'b0;
        w_cs_nxt    = 1'b1;
        w_clk_nxt   = 1'b0;
        w_di_nxt    = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_pending) begin
                    w_start = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_div_end) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            S_HIGH: begin
                if (w_div_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == '0) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_shreg_nxt = r_shreg << 1;
                        w_idx_nxt   = r_idx - IDX_W'(1);
                        w_state_nxt = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (w_div_end) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            S_HOLD: begin
                if (w_div_end) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_cnt_nxt = '0;
                    if (r_pending) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_start) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = '0;
            w_shreg_nxt = FRAME_BITS'({status, matrix});
            w_idx_nxt   = IDX_W'(FRAME_BITS - 1);
            w_busy_nxt  = 1'b1;
        end

        w_in_frame = (w_state_nxt == S_SETUP) || (w_state_nxt == S_HIGH) ||
                     (w_state_nxt == S_LOW)   || (w_state_nxt == S_HOLD);
        w_cs_nxt   = ~w_in_frame;
        w_clk_nxt  = (w_state_nxt == S_HIGH);
        w_di_nxt   = w_in_frame ? w_shreg_nxt[FRAME_BITS-1] : 1'b1;
    end

endmodule

// File: tb/tb_kbd_spi_tx.sv
// tb_kbd_spi_tx: timeline model of the SPI frame plus directed scenarios for kbd_spi_tx.
`timescale 1ns/1ps
module tb_kbd_spi_tx;

    localparam int CLK_DIV    = 7;
    localparam int FRAME_BITS = 48;
    localparam int GAP_CYCLES = 14;
    localparam int CS_LOW     = CLK_DIV * (1 + 2 * FRAME_BITS);
    localparam int BUSY_LEN   = CS_LOW + GAP_CYCLES;

    logic        clk14m   = 1'b0;
    logic        rst      = 1'b0;
    logic [39:0] matrix   = '1;
    logic [7:0]  status   = '0;
    logic        send_req = 1'b0;
    logic        no_req   = 1'b0;

    logic cs0, sck0, di0, busy0, done0;
    logic cs1, sck1, di1, busy1, done1;
    logic cs2, sck2, di2, busy2, done2;

    kbd_spi_tx #(.CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS), .AUTO_PERIOD(0), .GAP_CYCLES(GAP_CYCLES)) u_dut (
        .clk14m(clk14m), .rst(rst), .matrix(matrix), .status(status), .send_req(send_req),
        .kbd_cs(cs0), .kbd_clk(sck0), .kbd_di(di0), .busy(busy0), .done(done0));

    kbd_spi_tx #(.CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS), .AUTO_PERIOD(2000), .GAP_CYCLES(GAP_CYCLES)) u_auto2k (
        .clk14m(clk14m), .rst(rst), .matrix(matrix), .status(status), .send_req(no_req),
        .kbd_cs(cs1), .kbd_clk(sck1), .kbd_di(di1), .busy(busy1), .done(done1));

    kbd_spi_tx #(.CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS), .AUTO_PERIOD(500), .GAP_CYCLES(GAP_CYCLES)) u_auto500 (
        .clk14m(clk14m), .rst(rst), .matrix(matrix), .status(status), .send_req(no_req),
        .kbd_cs(cs2), .kbd_clk(sck2), .kbd_di(di2), .busy(busy2), .done(done2));

    always #5 clk14m = ~clk14m;

    int cyc = 0;
    always @(posedge clk14m) cyc <= cyc + 1;

    // Timeline model: a frame is a 693-cycle window starting when a request is pending and the link is free.
    logic        m_active = 1'b0;
    int          m_k      = 0;
    logic        m_pend   = 1'b0;
    logic        m_start;
    logic [47:0] m_frame  = '0;

    always @(posedge clk14m or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_pend   <= 1'b0;
        end else begin
            m_start = m_pend && (!m_active || m_k == BUSY_LEN - 1);
            if (m_start) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_frame  <= {status, matrix};
            end else if (m_active) begin
                if (m_k == BUSY_LEN - 1) m_active <= 1'b0;
                else                     m_k <= m_k + 1;
            end
            m_pend <= send_req | (m_pend & ~m_start);
        end
    end

    // Expected {cs, sck, di, busy, done} at offset k of a frame window.
    function automatic logic [4:0] expect_out(logic act, int k, logic [47:0] fr);
        int p;
        int b;
        if (!act) return 5'b10100;
        if (k >= CS_LOW) return {1'b1, 1'b0, 1'b1, 1'b1, (k == CS_LOW)};
        p = k / CLK_DIV;
        b = p / 2;
        if (b > 47) b = 47;
        return {1'b0, p[0], fr[47 - b], 1'b1, 1'b0};
    endfunction

    int errors = 0;
    int checks = 0;

    // Monitor state for u_dut
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0;
    logic [47:0] cap = '0;
    logic [47:0] q_frames[$];
    int cs_run = 0, edges = 0, high_run = 0, last_high_run = 0;
    int last_len = 0, last_edges = 0, frame_cnt = 0;
    int done_cnt = 0, done_cyc = 0, busy_fall_gap = 0, cs_fall_cyc = 0, req_cyc = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One clock step: compare against the model, then update the frame monitor.
    task automatic tick();
        logic [4:0] exp_o;
        logic [4:0] act_o;
        @(negedge clk14m);
        exp_o = expect_out(m_active, m_k, m_frame);
        act_o = {cs0, sck0, di0, busy0, done0};
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            if (errors <= 20)
                $display("FAIL cycle_model cyc=%0d got cs/sck/di/busy/done=%b expected=%b", cyc, act_o, exp_o);
        end
        if (rst) begin
            cs_run = 0; edges = 0; cap = '0; high_run = 0;
        end else begin
            if (!cs0) begin
                if (prev_cs) begin
                    cs_fall_cyc   = cyc;
                    last_high_run = high_run;
                end
                cs_run++;
                if (sck0 && !prev_sck) begin
                    cap = {cap[46:0], di0};
                    edges++;
                end
            end else begin
                if (!prev_cs) begin
                    q_frames.push_back(cap);
                    last_len   = cs_run;
                    last_edges = edges;
                    frame_cnt++;
                    cs_run = 0; edges = 0; high_run = 0;
                end
                high_run++;
            end
            if (done0) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_busy && !busy0) busy_fall_gap = cyc - done_cyc;
        end
        prev_cs   = cs0;
        prev_sck  = sck0;
        prev_busy = busy0;
    endtask

    task automatic pulse_req();
        req_cyc  = cyc;
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
    endtask

    task automatic wait_frames(int target, int budget, string what);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (frame_cnt < target) begin
            errors++;
            $display("FAIL %s timeout frames=%0d expected=%0d", what, frame_cnt, target);
        end
    endtask

    task automatic wait_edges(int target, int budget, string what);
        int n = 0;
        while (edges < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (edges < target) begin
            errors++;
            $display("FAIL %s timeout edges=%0d expected=%0d", what, edges, target);
        end
    endtask

    task automatic check_frame(string name, logic [47:0] exp);
        logic [47:0] got;
        checks++;
        if (q_frames.size() == 0) begin
            errors++;
            $display("FAIL %s no frame captured expected=%h", name, exp);
        end else begin
            got = q_frames.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s got=%h expected=%h", name, got, exp);
            end
        end
    endtask

    // Auto-refresh monitors: CS falling cycles (2000 period) and CS-high runs between frames (500 period).
    int   a2k_falls[$];
    int   a500_highs[$];
    logic p1 = 1'b1, p2 = 1'b1, a500_seen = 1'b0;
    int   h2 = 0;

    always @(negedge clk14m) begin
        if (rst) a2k_falls.delete();
        else if (p1 && !cs1) a2k_falls.push_back(cyc);
        p1 <= cs1;
    end

    always @(negedge clk14m) begin
        if (rst) begin
            a500_highs.delete();
            h2        <= 0;
            a500_seen <= 1'b0;
        end else if (cs2) begin
            h2 <= h2 + 1;
        end else begin
            if (p2) begin
                if (a500_seen) a500_highs.push_back(h2);
                a500_seen <= 1'b1;
            end
            h2 <= 0;
        end
        p2 <= cs2;
    end

    int base;

    initial begin
        #1 rst = 1'b1;
        repeat (3) tick();
        check("reset_cs",   64'(cs0),   64'd1);
        check("reset_sck",  64'(sck0),  64'd0);
        check("reset_di",   64'(di0),   64'd1);
        check("reset_busy", 64'(busy0), 64'd0);
        check("reset_done", 64'(done0), 64'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Single frame
        matrix = 40'hFF_FFFF_FFFE;
        status = 8'h05;
        tick();
        q_frames.delete();
        done_cnt = 0;
        base = frame_cnt;
        pulse_req();
        wait_frames(base + 1, 1000, "single_frame");
        repeat (GAP_CYCLES + 4) tick();
        check("single_latency",  64'(cs_fall_cyc - req_cyc), 64'd2);
        check_frame("single_bits", 48'h05FF_FFFF_FFFE);
        check("single_cs_len",   64'(last_len),      64'd679);
        check("single_edges",    64'(last_edges),    64'd48);
        check("single_done_cnt", 64'(done_cnt),      64'd1);
        check("single_busy_gap", 64'(busy_fall_gap), 64'd14);

        // Snapshot: matrix changes mid-frame only affect the next frame
        matrix = 40'h12_3456_789A;
        status = 8'hA5;
        q_frames.delete();
        base = frame_cnt;
        pulse_req();
        wait_edges(20, 1000, "snapshot_bit20");
        matrix = 40'h0;
        pulse_req();
        wait_frames(base + 2, 2500, "snapshot_frames");
        repeat (GAP_CYCLES + 6) tick();
        check_frame("snapshot_old", 48'hA5_12_3456_789A);
        check_frame("snapshot_new", 48'hA5_00_0000_0000);

        // Coalescing: three requests during a busy frame give one more frame
        matrix = 40'h00_FF00_FF00;
        status = 8'h3C;
        q_frames.delete();
        base = frame_cnt;
        pulse_req();
        wait_edges(5, 1000, "coalesce_edge5");
        pulse_req();
        repeat (100) tick();
        pulse_req();
        wait_edges(40, 1000, "coalesce_edge40");
        pulse_req();
        wait_frames(base + 2, 2500, "coalesce_frames");
        check("coalesce_gap_ge14", 64'(last_high_run >= GAP_CYCLES), 64'd1);
        repeat (1500) tick();
        check("coalesce_count", 64'(frame_cnt - base), 64'd2);
        check_frame("coalesce_f1", 48'h3C_00_FF00_FF00);
        check_frame("coalesce_f2", 48'h3C_00_FF00_FF00);

        // Reset mid-frame, then a clean full frame
        matrix = 40'hF0_0F0F_F00F;
        status = 8'h81;
        q_frames.delete();
        base = frame_cnt;
        pulse_req();
        wait_edges(20, 1000, "reset_bit20");
        rst = 1'b1;
        #1;
        check("midrst_cs",   64'(cs0),   64'd1);
        check("midrst_sck",  64'(sck0),  64'd0);
        check("midrst_di",   64'(di0),   64'd1);
        check("midrst_busy", 64'(busy0), 64'd0);
        repeat (4) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("midrst_no_partial", 64'(frame_cnt - base), 64'd0);
        pulse_req();
        wait_frames(base + 1, 1000, "midrst_frame");
        check_frame("midrst_bits", 48'h81_F0_0F0F_F00F);
        check("midrst_edges", 64'(last_edges), 64'd48);
        check("midrst_cs_len", 64'(last_len), 64'd679);

        // Auto-refresh instances from a fresh reset
        repeat (20) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (7000) tick();
        check("auto2k_frames_ge3", 64'(a2k_falls.size() >= 3), 64'd1);
        if (a2k_falls.size() >= 3) begin
            check("auto2k_period_a", 64'(a2k_falls[1] - a2k_falls[0]), 64'd2000);
            check("auto2k_period_b", 64'(a2k_falls[2] - a2k_falls[1]), 64'd2000);
        end
        check("auto500_gaps_ge4", 64'(a500_highs.size() >= 4), 64'd1);
        if (a500_highs.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("auto500_gap", 64'(a500_highs[i]), 64'd14);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
